// File: rtl/vga_fb.sv
// Writable VGA framebuffer with colour expansion, valid/ready write port and a full-frame clear
// engine. Define VGA_FB_SCALE2X_EN to store a half-resolution frame shown as 2x2 screen blocks.
module vga_fb #(
    parameter int unsigned H_RES    = 640,
    parameter int unsigned V_RES    = 480,
    parameter int unsigned PIX_W    = 12,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [9:0]       h_addr,
    input  logic [9:0]       v_addr,
    output logic [23:0]      vga_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [9:0]       wr_x,
    input  logic [9:0]       wr_y,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             clr_req,
    input  logic [PIX_W-1:0] clr_color,
    output logic             busy
);

`ifdef VGA_FB_SCALE2X_EN
    localparam int unsigned SW    = H_RES / 2;
    localparam int unsigned SH    = V_RES / 2;
    localparam int unsigned SHIFT = 1;
`else
    localparam int unsigned SW    = H_RES;
    localparam int unsigned SH    = V_RES;
    localparam int unsigned SHIFT = 0;
`endif
    localparam int unsigned XB = $clog2(SW);
    localparam int unsigned YB = $clog2(SH);
    localparam int unsigned AW = XB + YB;
    localparam int unsigned C  = PIX_W / 3;

    localparam logic [10:0]   SW_C    = 11'(SW);
    localparam logic [10:0]   SH_C    = 11'(SH);
    localparam logic [10:0]   H_RES_C = 11'(H_RES);
    localparam logic [10:0]   V_RES_C = 11'(V_RES);
    localparam logic [XB-1:0] X_LAST  = XB'(SW - 1);
    localparam logic [YB-1:0] Y_LAST  = YB'(SH - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_t;

    state_t            state_q, state_d;
    logic [XB-1:0]     cx_q, cx_d;
    logic [YB-1:0]     cy_q, cy_d;
    logic [PIX_W-1:0]  color_q, color_d;

    logic [PIX_W-1:0]  mem [0:(1 << AW) - 1];
    logic [PIX_W-1:0]  pix_q;
    logic              vis_q, out_en_q;

    logic [9:0]        rx, ry;
    logic              rd_vis;
    logic [AW-1:0]     rd_addr;
    logic              wr_in_range;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [PIX_W-1:0]  mem_wdata;
    logic              unused_bits;

    // Replicate a C-bit component MSB-first to fill 8 bits.
    function automatic logic [7:0] expand(input logic [C-1:0] c);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[7-i] = c[C-1-(i%C)];
        end
        return r;
    endfunction

    assign rx          = h_addr >> SHIFT;
    assign ry          = v_addr >> SHIFT;
    assign rd_vis      = ({1'b0, h_addr} < H_RES_C) && ({1'b0, v_addr} < V_RES_C);
    assign rd_addr     = {ry[YB-1:0], rx[XB-1:0]};
    assign wr_in_range = ({1'b0, wr_x} < SW_C) && ({1'b0, wr_y} < SH_C);
    assign unused_bits = ^{rx, ry, wr_x, wr_y, h_addr, v_addr};

    always_comb begin
        mem_we    = wr_valid && wr_ready && wr_in_range;
        mem_waddr = {wr_y[YB-1:0], wr_x[XB-1:0]};
        mem_wdata = wr_data;
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = {cy_q, cx_q};
            mem_wdata = color_q;
        end
    end

    // Block RAM: no reset, read-first on a same-address collision.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        pix_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vis_q    <= 1'b0;
            out_en_q <= 1'b0;
        end else begin
            vis_q    <= rd_vis;
            out_en_q <= 1'b1;
        end
    end

    always_comb begin
        if (!out_en_q) begin
            vga_data = 24'h0;
        end else if (vis_q) begin
            vga_data = {expand(pix_q[3*C-1 -: C]), expand(pix_q[2*C-1 -: C]),
                        expand(pix_q[C-1:0])};
        end else begin
            vga_data = BG_COLOR;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cx_q    <= '0;
            cy_q    <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            color_q <= color_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        color_d  = color_q;
        busy     = 1'b0;
        wr_ready = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    color_d = clr_color;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                busy     = 1'b1;
                wr_ready = 1'b0;
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    if (cy_q == Y_LAST) begin
                        state_d = StIdle;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_vga_fb.sv
// Scoreboard bench for vga_fb on a reduced 80x60 frame; a pixel-array model supplies every
// expected value and a negedge monitor compares queued expectations against vga_data.
module tb_vga_fb;

    localparam int H_RES = 80;
    localparam int V_RES = 60;
    localparam int PIX_W = 12;
    localparam int C     = PIX_W / 3;
    localparam logic [23:0] BG = 24'h2A5B7C;
`ifdef VGA_FB_SCALE2X_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif
    localparam int SW   = H_RES >> S;
    localparam int SH   = V_RES >> S;
    localparam int NPIX = SW * SH;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [9:0]       h_addr = '0, v_addr = '0;
    logic [23:0]      vga_data;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [9:0]       wr_x = '0, wr_y = '0;
    logic [PIX_W-1:0] wr_data = '0;
    logic             clr_req = 1'b0;
    logic [PIX_W-1:0] clr_color = '0;
    logic             busy;

    vga_fb #(.H_RES(H_RES), .V_RES(V_RES), .PIX_W(PIX_W), .BG_COLOR(BG)) dut (
        .clk(clk), .resetn(resetn), .h_addr(h_addr), .v_addr(v_addr), .vga_data(vga_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .clr_req(clr_req), .clr_color(clr_color), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [PIX_W-1:0] mdl [NPIX];
    logic [23:0]      exp_q [$];
    string            nm_q [$];
    int               n_chk = 0;
    int               n_fail = 0;
    logic             probe = 1'b0;
    logic             probe_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Replicate each component by repeated concatenation, then keep the top 8 bits.
    function automatic logic [23:0] expand(input logic [PIX_W-1:0] p);
        int res = 0;
        for (int k = 0; k < 3; k++) begin
            int comp = int'(p >> (C * (2 - k))) & ((1 << C) - 1);
            int acc = comp;
            int w = C;
            while (w < 8) begin
                acc = (acc << C) | comp;
                w += C;
            end
            res = res | (((acc >> (w - 8)) & 8'hFF) << (8 * (2 - k)));
        end
        return 24'(res);
    endfunction

    function automatic logic [23:0] model_rd(input int h, input int v);
        if (h >= H_RES || v >= V_RES) return BG;
        return expand(mdl[(v >> S) * SW + (h >> S)]);
    endfunction

    always @(posedge clk) probe_q <= probe;

    always @(negedge clk) begin : monitor
        logic [23:0] e;
        string nm;
        check("ready_vs_busy", 32'(wr_ready), 32'(!busy));
        if (probe_q) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got no expectation, required one");
            end else begin
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                check(nm, 32'(vga_data), 32'(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_px(input int h, input int v, input string nm);
        h_addr = 10'(h);
        v_addr = 10'(v);
        probe  = 1'b1;
        exp_q.push_back(model_rd(h, v));
        nm_q.push_back(nm);
        step();
        probe = 1'b0;
    endtask

    task automatic write_px(input int x, input int y, input logic [PIX_W-1:0] pix);
        wr_valid = 1'b1;
        wr_x     = 10'(x);
        wr_y     = 10'(y);
        wr_data  = pix;
        @(negedge clk);
        check("wr_ready_idle", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        if (x < SW && y < SH) mdl[y * SW + x] = pix;
    endtask

    // Read and write the same stored pixel in one cycle: the read must see the old value.
    task automatic rw_same(input int x, input int y, input logic [PIX_W-1:0] pix);
        h_addr = 10'(x << S);
        v_addr = 10'(y << S);
        probe  = 1'b1;
        exp_q.push_back(model_rd(x << S, y << S));
        nm_q.push_back("read_first");
        write_px(x, y, pix);
        probe = 1'b0;
    endtask

    task automatic do_clear(input logic [PIX_W-1:0] color, input int abort_at,
                            input int extra_at, input bit with_wr);
        int cnt = 0;
        bit aborted = 1'b0;
        clr_req   = 1'b1;
        clr_color = color;
        if (with_wr) begin
            wr_valid = 1'b1;
            wr_x     = 10'd1;
            wr_y     = 10'd1;
            wr_data  = '1;
        end
        @(negedge clk);
        if (with_wr) check("wr_ready_with_clr", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
        clr_req   = 1'b0;
        wr_valid  = 1'b0;
        clr_color = PIX_W'($urandom);
        if (with_wr) mdl[SW + 1] = '1;
        forever begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            if (cnt == extra_at) clr_req = 1'b1;
            if (cnt == extra_at + 1) clr_req = 1'b0;
            if (cnt == abort_at) begin
                resetn = 1'b0;
                #1;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_ready", 32'(wr_ready), 32'd1);
                check("abort_vga_data", 32'(vga_data), 32'd0);
                for (int i = 0; i < cnt - 1; i++) mdl[i] = color;
                aborted = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                resetn = 1'b1;
                break;
            end
            if (cnt > NPIX + 10) begin
                check("clear_timeout", 32'(cnt), 32'(NPIX));
                break;
            end
        end
        if (!aborted) begin
            check("clear_len", 32'(cnt), 32'(NPIX));
            for (int i = 0; i < NPIX; i++) mdl[i] = color;
        end
        step();
    endtask

    initial begin : timeout
        #(100000 * 10);
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        repeat (3) begin
            @(negedge clk);
            check("reset_vga_data", 32'(vga_data), 32'd0);
            check("reset_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step();

        // Establish known memory contents.
        do_clear('0, 0, 0, 1'b0);

        write_px(3, 5, 12'hF80);
        read_px(3 << S, 5 << S, "expand_F80");
        read_px(700, 10, "blank_h700");
        read_px(10, 500, "blank_v500");
        read_px(H_RES, 0, "blank_h_edge");
        read_px(0, V_RES, "blank_v_edge");

        write_px(SW - 1, SH - 1, 12'h00F);
        write_px(SW, 0, 12'hFFF);
        read_px(H_RES - 1, V_RES - 1, "last_pixel");
        read_px(0, 0, "origin_untouched");

        for (int n = 0; n < 200; n++) begin
            int op = int'($urandom_range(0, 3));
            case (op)
                0: write_px(int'($urandom_range(0, SW - 1)), int'($urandom_range(0, SH - 1)),
                            PIX_W'($urandom));
                1: write_px(int'($urandom_range(0, SW + 20)), int'($urandom_range(0, SH + 10)),
                            PIX_W'($urandom));
                2: read_px(int'($urandom_range(0, H_RES + 30)),
                           int'($urandom_range(0, V_RES + 30)), "rand_read");
                default: rw_same(int'($urandom_range(0, SW - 1)),
                                 int'($urandom_range(0, SH - 1)), PIX_W'($urandom));
            endcase
        end
        for (int n = 0; n < 20; n++)
            read_px(int'($urandom_range(0, H_RES - 1)), int'($urandom_range(0, V_RES - 1)),
                    "rand_visible");

        // Second request mid-clear must not extend the clear.
        do_clear(12'h0F0, 0, 100, 1'b0);
        read_px(0, 0, "clr_origin");
        read_px(H_RES - 1, V_RES - 1, "clr_last");
        read_px(H_RES / 2, V_RES / 2, "clr_center");

        do_clear(12'h5A3, 0, 0, 1'b1);
        read_px(1 << S, 1 << S, "clr_beats_write");

        rw_same(2, 2, 12'hA5C);
        read_px(2 << S, 2 << S, "after_rw_new");

        write_px(10, 10, 12'h00F);
        read_px(20, 20, "blk_20_20");
        read_px(21, 20, "blk_21_20");
        read_px(20, 21, "blk_20_21");
        read_px(21, 21, "blk_21_21");
        read_px(22, 20, "blk_22_20");

        write_px(0, SH - 1, 12'hABC);
        do_clear(12'h3C7, 1000, 0, 1'b0);
        read_px(5 << S, 0, "abort_cleared");
        read_px(0, (SH - 1) << S, "abort_prior");
        read_px(H_RES - 1, V_RES - 1, "abort_tail");

        repeat (3) step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb.md
# vga_fb

Parametrised, writable VGA framebuffer replacing the fixed 24-bit read-only picture memory between `vga_ctrl` and the board. Pixels are stored at a configurable colour depth and expanded to 24-bit RGB on a registered read port driven by `h_addr`/`v_addr`. A valid/ready write port lets logic such as keyboard-driven drawing update pixels. A built-in clear engine fills the whole frame with one colour.

## Interface
Parameters:
- `H_RES`, 640: visible pixels per line.
- `V_RES`, 480: visible lines.
- `PIX_W`, 12: stored bits per pixel; multiple of 3, at most 24.
- `BG_COLOR`, 24'h000000: output colour outside the visible area.

Ports:
- `clk`  in  1: pixel clock, shared with `vga_ctrl`.
- `resetn`  in  1: asynchronous, active-low reset.
- `h_addr`  in  10: current column from `vga_ctrl`.
- `v_addr`  in  10: current line from `vga_ctrl`.
- `vga_data`  out  24: registered RGB888 pixel, {R,G,B}.
- `wr_valid`  in  1: write request.
- `wr_ready`  out  1: write accepted when high together with `wr_valid`.
- `wr_x`  in  10: write column, in storage coordinates.
- `wr_y`  in  10: write line, in storage coordinates.
- `wr_data`  in  PIX_W: pixel to store.
- `clr_req`  in  1: start a full-frame clear; level sampled in IDLE.
- `clr_color`  in  PIX_W: fill colour, captured when the clear starts.
- `busy`  out  1: clear engine active.

## Operation
- **Storage.** Storage is SW × SH pixels: SW = `H_RES`, SH = `V_RES` (halved with scaling; see Configuration). Address = {y[YB-1:0], x[XB-1:0]}, where XB = clog2(SW) and YB = clog2(SH). Depth is 2^(XB+YB), inferred as block RAM. Memory contents are not reset.
- **Read.** Each cycle, sample (`h_addr`, `v_addr`) and map them to storage coordinates.
  - If `h_addr` ≥ `H_RES` or `v_addr` ≥ `V_RES`, `vga_data` = `BG_COLOR`.
  - Otherwise, read the pixel and expand it. With C = `PIX_W`/3, each component is replicated MSB-first to fill 8 bits. Example: C=4, 4'hA → 8'hAA. When C=8 the value passes through unchanged.
- **Write.** A write happens when `wr_valid` && `wr_ready`.
  - If `wr_x` ≥ SW or `wr_y` ≥ SH, the write is accepted and dropped.
  - `wr_ready` = 1 in IDLE and 0 in CLEAR. It is combinational from state only.
- **FSM states:**
  - IDLE: `busy`=0. If `clr_req`=1, latch `clr_color`, reset the sweep counters to (0,0), and go to CLEAR.
  - CLEAR: `busy`=1. Each cycle, write `clr_color` at (cx,cy). cx increments and wraps at SW-1, then cy increments. After writing (SW-1,SH-1), go to IDLE.
- **Clear-engine boundaries.**
  - `clr_req` during CLEAR is ignored; it does not restart or queue a clear.
  - If `clr_req` and a write occur in the same IDLE cycle, the write is committed that cycle and the clear starts next cycle, so the clear overwrites it.
  - Reset mid-clear aborts immediately; the memory is left partially cleared.
- **Read-during-write to the same address:** the read returns the old data (read-first).

## Timing
- Read latency is 1 cycle: `vga_data` at edge n+1 reflects the address sampled at edge n. `vga_ctrl` timing tolerates this one-pixel shift.
- A write is visible to a read issued on the cycle after the write edge.
- A clear occupies exactly SW·SH cycles in CLEAR:
  - 307200 cycles at the defaults.
  - 76800 cycles with scaling.
  - `busy` rises on the edge after `clr_req` is sampled and falls on the edge after the last fill write.
- Reset values: `vga_data`=24'h0, `busy`=0, `wr_ready`=1 (IDLE), sweep counters 0.

## Configuration
- `VGA_FB_SCALE2X_EN` defined:
  - SW = `H_RES`/2 and SH = `V_RES`/2.
  - Read coordinates are `h_addr`>>1 and `v_addr`>>1, so each stored pixel covers a 2×2 screen block.
  - Write and clear coordinates are in the halved space.
  - Visible-area checks still use the unshifted `h_addr`/`v_addr` against `H_RES`/`V_RES`.
- Undefined: 1:1 mapping, SW = `H_RES` and SH = `V_RES`.

## Test plan
- **Reset and expansion.** Assert `resetn`=0, then release; write (3,5) = 12'hF80; read `h_addr`=3, `v_addr`=5 → `vga_data`=24'hFF8800 one cycle later. `busy`=0 throughout.
- **Blanking.** Drive `h_addr`=700, `v_addr`=10 → `BG_COLOR`. Drive `h_addr`=10, `v_addr`=500 → `BG_COLOR`.
- **Out-of-range write.** Write (639,479) = 12'h00F, then write (640,0) = 12'hFFF. Both handshakes complete. Readback (639,479) = 24'h0000FF. Storage address {0, 640} is unchanged.
- **Clear.** Pulse `clr_req` with `clr_color`=12'h0F0.
  - `busy` is high for exactly 307200 cycles (76800 with the macro) and `wr_ready`=0 for the same span.
  - Afterwards, sampled pixels (0,0), (639,479) and (320,240) read 24'h00FF00.
  - A second `clr_req` mid-clear does not extend `busy`.
- **Simultaneous events.** In IDLE, assert `clr_req` and write (1,1) = 12'hFFF in the same cycle. The write handshakes, and after the clear, (1,1) reads the clear colour. Separately, a same-cycle read and write of (2,2) returns the old value, and the new value appears on the next read.
- **Reset mid-clear and scaling.**
  - Assert `resetn`=0 at cycle 1000 of a clear: `busy`=0 and `wr_ready`=1 immediately. Pixel (5,0) holds the clear colour; pixel (0,100) holds its prior value.
  - With `VGA_FB_SCALE2X_EN`: write (10,10) = 12'h00F; reads at (20..21, 20..21) return 24'h0000FF, and (22,20) does not.
